// File: rtl/farm_road_detector_pkg.sv
// Shared constants for the farm-road detector and the traffic light controller.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package farm_road_detector_pkg;

    // Farm-road lamp codes. They are one-hot, so any other value is a corrupted code.
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    // Request FSM encoding. IDLE must stay 0 because that is the reset value.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SERVE = 2'd2
    } farm_state_t;

    function automatic logic lamp_legal(input logic [2:0] code);
        return (code == LAMP_GREEN) || (code == LAMP_YELLOW) || (code == LAMP_RED);
    endfunction

endpackage

// File: rtl/loop_debounce.sv
// Synchronizes the raw inductive-loop level and debounces it, flagging each accepted rise.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES to move level; rise pulses in the cycle level becomes 1.
// Backpressure: none; free-running sampler.
// Ports: clk, rst (async active-high), loop_in (async raw level),
//        level (debounced level), rise (one-cycle pulse on level 0->1).
module loop_debounce #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic loop_in,
    output logic level,
    output logic rise
);

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic       sync_q1;
    logic       sync_q2;
    logic [3:0] deb_cnt;
    logic [3:0] deb_cnt_nxt;
    logic       level_nxt;

    // Count consecutive synchronized samples that disagree with the accepted level;
    // one agreeing sample throws the partial count away.
    always_comb begin
        level_nxt   = level;
        deb_cnt_nxt = '0;
        if (sync_q2 != level) begin
            if (deb_cnt == DEB_LAST) begin
                level_nxt = sync_q2;
            end else begin
                deb_cnt_nxt = deb_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            deb_cnt <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_q1 <= loop_in;
            sync_q2 <= sync_q1;
            deb_cnt <= deb_cnt_nxt;
            level   <= level_nxt;
            rise    <= level_nxt & ~level;
        end
    end

endmodule

// File: rtl/farm_road_detector.sv
// Counts vehicles queued on the farm road and raises a service request S to the light controller.
// Latency: loop rise to S=1 is 2 + DEBOUNCE_CYCLES + 1 cycles; departures every PASS_CYCLES green cycles.
// Backpressure: none; arrivals beyond MAX_CARS are dropped and flagged by sticky overflow.
// Ports: clk, rst (async active-high), loop_in (raw loop level), light_farm (lamp code),
//        S (request), car_count (queue depth), overflow (sticky), fault (sticky illegal lamp code).
module farm_road_detector
    import farm_road_detector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int PASS_CYCLES     = 2,
    parameter int MAX_CARS        = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       loop_in,
    input  logic [2:0] light_farm,
    output logic       S,
    output logic [3:0] car_count,
    output logic       overflow,
    output logic       fault
);

    localparam logic [3:0] PASS_LAST = 4'(PASS_CYCLES - 1);
    localparam logic [3:0] CAR_MAX   = 4'(MAX_CARS);

    logic        loop_level;
    logic        loop_rise;
    logic        arrival;
    logic        departure;
    logic        farm_green;
    logic [3:0]  pass_cnt;
    logic [3:0]  count_nxt;
    logic        ovf_set;
    farm_state_t state;
    farm_state_t state_nxt;

    loop_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_loop_debounce (
        .clk     (clk),
        .rst     (rst),
        .loop_in (loop_in),
        .level   (loop_level),
        .rise    (loop_rise)
    );

    // The rise pulse is registered alongside the level, so the level is always 1
    // while it is asserted; the AND only documents that an arrival is a confirmed vehicle.
    assign arrival = loop_rise & loop_level;

    // An illegal lamp code is deliberately not green: never release cars on a corrupt code.
    assign farm_green = (light_farm == LAMP_GREEN);
    assign departure  = farm_green && (pass_cnt == PASS_LAST) && (car_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= '0;
        end else if (!farm_green || (pass_cnt == PASS_LAST)) begin
            pass_cnt <= '0;
        end else begin
            pass_cnt <= pass_cnt + 4'd1;
        end
    end

    // A coincident arrival and departure cancel, so a full queue does not flag overflow then.
    always_comb begin
        count_nxt = car_count;
        ovf_set   = 1'b0;
        if (arrival && !departure) begin
            if (car_count == CAR_MAX) begin
                ovf_set = 1'b1;
            end else begin
                count_nxt = car_count + 4'd1;
            end
        end else if (departure && !arrival) begin
            count_nxt = car_count - 4'd1;
        end
    end

    // State follows the count it will hold next cycle, so S never lags car_count.
    always_comb begin
        state_nxt = ST_IDLE;
        if (count_nxt != '0) begin
            state_nxt = farm_green ? ST_SERVE : ST_WAIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            car_count <= '0;
            overflow  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nxt;
            car_count <= count_nxt;
            overflow  <= overflow | ovf_set;
            fault     <= fault | ~lamp_legal(light_farm);
        end
    end

    assign S = (state != ST_IDLE);

endmodule

// File: doc/farm_road_detector.md
FARM_ROAD_DETECTOR -- requirements
Module: farm_road_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 3, number of consecutive equal synchronized loop samples required to accept a level change (range 1..15).
REQ-002 Parameter PASS_CYCLES, default 2, farm-green cycles per departing vehicle (range 1..15).
REQ-003 Parameter MAX_CARS, default 15, saturation value of the vehicle counter (range 1..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high; this is already decided.
REQ-006 loop_in  input  1  raw inductive-loop detector level, asynchronous to clk, 1 = vehicle over loop.
REQ-007 light_farm  input  3  farm-road lamp code from the traffic light controller: 3'b001 green, 3'b010 yellow, 3'b100 red.
REQ-008 S  output  1  registered farm-road request to the controller, 1 = vehicles waiting.
REQ-009 car_count  output  4  registered number of vehicles queued on the farm road.
REQ-010 overflow  output  1  sticky flag, 1 = an arrival was dropped at MAX_CARS.
REQ-011 fault  output  1  sticky flag, 1 = illegal light_farm code seen.

Function
REQ-012 loop_in shall pass through a 2-flop synchronizer before any use; synchronizer latency is 2 cycles.
REQ-013 The debounced level shall change only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current debounced level; any intervening matching sample restarts the count.
REQ-014 A 0->1 transition of the debounced level shall be one arrival event, lasting exactly one cycle.
REQ-015 While light_farm == green, a pass counter shall increment each cycle; when it reaches PASS_CYCLES-1 with car_count > 0, it shall generate one departure event and wrap to 0.
REQ-016 The pass counter shall clear to 0 in any cycle light_farm != green.
REQ-017 Arrival alone shall increment car_count; if car_count == MAX_CARS, car_count shall hold and overflow shall set.
REQ-018 Departure alone shall decrement car_count; departure shall never occur at car_count == 0.
REQ-019 Simultaneous arrival and departure shall leave car_count unchanged and shall not set overflow.
REQ-020 FSM states and transitions:
- IDLE: car_count == 0.
- WAIT: car_count > 0 and farm not green.
- SERVE: car_count > 0 and farm green.
- Next state is evaluated from next car_count and current light_farm.
- SERVE -> IDLE when the last vehicle departs.
- SERVE -> WAIT when farm leaves green with vehicles remaining.
REQ-021 S shall be 1 exactly when the registered state is WAIT or SERVE; S therefore reflects car_count in the same cycle.
REQ-022 light_farm values other than 001/010/100 shall set fault.
- The illegal code shall be treated as not-green.
- car_count and S shall keep operating.
REQ-023 overflow and fault shall clear only on reset.
REQ-024 Arrival to S=1 latency shall be 2 + DEBOUNCE_CYCLES + 1 cycles from the loop_in rising edge, given stable input.

Reset
REQ-025 While rst = 1, the following shall be 0 asynchronously:
- S, car_count, overflow, fault;
- synchronizer flops, debounced level, debounce counter, pass counter;
- FSM state (IDLE).
REQ-026 Reset asserted mid-queue shall discard all queued vehicles.
- A loop held at 1 through reset deassertion shall count as one new arrival after debounce.
- Sampling resumes on the first rising clk edge after rst falls.

Structure
REQ-027 The lamp codes (GREEN, YELLOW, RED) and the FSM state encoding shall be constants in a shared package used by both this block and the traffic light controller.
REQ-028 Synchronizer plus debounce shall be one sub-module, loop_debounce, which outputs the debounced level and the one-cycle rise pulse.

Verification
REQ-029 Bench shall cover, with defaults:
- Glitch rejection: loop_in = 1 for 2 cycles, then 0 -> car_count stays 0, S stays 0.
- Single car: loop_in = 1 held, light_farm = 100 -> S = 1 and car_count = 1 exactly 6 cycles after the loop_in rise.
- Service: 3 arrivals, then light_farm = 001 -> car_count goes 3->2->1->0 every 2 cycles; S = 0 in the cycle count reaches 0.
- Saturation: 16 arrivals with farm red -> car_count = 15, overflow = 1; a later departure gives 14 and overflow stays 1.
- Simultaneous: arrival pulse coincides with a departure at count 2 -> count stays 2; light_farm = 011 -> fault = 1, count unaffected.
- Reset mid-queue: rst pulsed at count 5 while clk is stopped -> all outputs 0 immediately; loop held at 1 -> count 1 after debounce.
